// File: rtl/barrel_shift_pipe_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Rotate support is selected by the SHIFTER_ROTATE_EN macro in shift_stage.
package shifter_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      SLL = 2'b00,
      SRL = 2'b01,
      SRA = 2'b10,
      ROR = 2'b11
   } shift_mode_t;

   // Bit offset of stage k's remaining-amount register inside the packed
   // triangular store: stage k keeps shw-1-k bits.
   function automatic int amt_off(input int shw, input int k);
      return k * (shw - 1) - (k * (k - 1)) / 2;
   endfunction

endpackage

// File: rtl/barrel_shift_pipe_if.sv
// Operand/result handshake bundle for barrel_shift_pipe.
// The slave side is the shifter; the master side is the producer/consumer.
interface barrel_shift_pipe_if #(
   parameter int WIDTH = 32
) ();
   import shifter_pkg::*;

   localparam int SHW = $clog2(WIDTH);

   logic                 in_valid;
   logic                 in_ready;
   logic [MODE_W-1:0]    in_mode;
   logic [SHW-1:0]       in_shift;
   logic [WIDTH-1:0]     in_num;
   logic                 out_valid;
   logic                 out_ready;
   logic [WIDTH-1:0]     out_data;

   modport master (
      output in_valid, in_mode, in_shift, in_num, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_mode, in_shift, in_num, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/barrel_shift_pipe_shift_stage.sv
// Single-distance combinational shifter used by one pipeline stage.
// With SHIFTER_ROTATE_EN defined mode ROR wraps; otherwise it falls back to SRL.
module shift_stage
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DIST  = 1
) (
   input  logic [WIDTH-1:0] din,
   input  shift_mode_t      mode,
   input  logic             en,
   output logic [WIDTH-1:0] dout
);

   always_comb begin
      dout = din;
      if (en) begin
         case (mode)
            SLL:     dout = {din[WIDTH-DIST-1:0], {DIST{1'b0}}};
            SRA:     dout = {{DIST{din[WIDTH-1]}}, din[WIDTH-1:DIST]};
`ifdef SHIFTER_ROTATE_EN
            ROR:     dout = {din[DIST-1:0], din[WIDTH-1:DIST]};
`endif
            default: dout = {{DIST{1'b0}}, din[WIDTH-1:DIST]};
         endcase
      end
   end

endmodule

// File: rtl/barrel_shift_pipe.sv
// Pipelined barrel shifter: one register stage per shift-amount bit, global stall.
// Rotate-right mode is enabled by defining SHIFTER_ROTATE_EN.
module barrel_shift_pipe
   import shifter_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic               clk,
   input  logic               rst,
   barrel_shift_pipe_if.slave bus
);

   localparam int SHW      = $clog2(WIDTH);
   localparam int AMT_BITS = (SHW * (SHW - 1)) / 2;

   logic                          advance;
   logic [SHW:0]                  vld_pipe;
   logic [SHW:0][WIDTH-1:0]       data_pipe;
   logic [SHW-1:0][MODE_W-1:0]    mode_pipe;
   logic [AMT_BITS-1:0]           amt_flat;

   assign advance       = !vld_pipe[SHW] || bus.out_ready;
   assign bus.in_ready  = advance;
   assign bus.out_valid = vld_pipe[SHW];
   assign bus.out_data  = data_pipe[SHW];

   assign vld_pipe[0]  = bus.in_valid;
   assign data_pipe[0] = bus.in_num;
   assign mode_pipe[0] = bus.in_mode;

   for (genvar k = 0; k < SHW; k++) begin : g_stg
      // RW = amount bits still to be applied on entry to this stage.
      localparam int RW = SHW - k;

      logic [RW-1:0]    amt_in;
      logic [WIDTH-1:0] shifted;
      logic             vld_d, vld_q;
      logic [WIDTH-1:0] data_d, data_q;

      if (k == 0) begin : g_amt_in
         assign amt_in = bus.in_shift;
      end else begin : g_amt_chain
         assign amt_in = amt_flat[amt_off(SHW, k-1) +: RW];
      end

      shift_stage #(
         .WIDTH (WIDTH),
         .DIST  (1 << k)
      ) u_shift (
         .din  (data_pipe[k]),
         .mode (shift_mode_t'(mode_pipe[k])),
         .en   (amt_in[0]),
         .dout (shifted)
      );

      always_comb begin
         vld_d  = vld_q;
         data_d = data_q;
         if (advance) begin
            vld_d  = vld_pipe[k];
            data_d = shifted;
         end
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q  <= 1'b0;
            data_q <= '0;
         end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
         end
      end

      assign vld_pipe[k+1]  = vld_q;
      assign data_pipe[k+1] = data_q;

      // The last stage has no successor, so it carries no mode/amount copy.
      if (k < SHW - 1) begin : g_ctl
         logic [MODE_W-1:0] mode_d, mode_q;
         logic [RW-2:0]     amt_d, amt_q;

         always_comb begin
            mode_d = mode_q;
            amt_d  = amt_q;
            if (advance) begin
               mode_d = mode_pipe[k];
               amt_d  = amt_in[RW-1:1];
            end
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               mode_q <= '0;
               amt_q  <= '0;
            end else begin
               mode_q <= mode_d;
               amt_q  <= amt_d;
            end
         end

         assign mode_pipe[k+1]                     = mode_q;
         assign amt_flat[amt_off(SHW, k) +: RW-1]  = amt_q;
      end
   end

endmodule

// File: tb/tb_barrel_shift_pipe.sv
// Directed self-checking bench for barrel_shift_pipe (WIDTH 32 and WIDTH 8).
// Rotate expectations follow SHIFTER_ROTATE_EN.
module tb_barrel_shift_pipe;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_chk = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   barrel_shift_pipe_if #(.WIDTH(32)) b32 ();
   barrel_shift_pipe_if #(.WIDTH(8))  b8 ();

   barrel_shift_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
   barrel_shift_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(b8));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic run32(input string tag, input logic [1:0] mode, input logic [4:0] sh,
                        input logic [31:0] num, input logic [31:0] exp);
      int lat;
      lat = 0;
      @(negedge clk);
      b32.out_ready = 1'b1;
      b32.in_mode   = mode;
      b32.in_shift  = sh;
      b32.in_num    = num;
      b32.in_valid  = 1'b1;
      while (lat < 20) begin
         @(negedge clk);
         b32.in_valid = 1'b0;
         lat++;
         if (b32.out_valid) break;
      end
      check({tag, "_lat"}, lat, 5);
      check(tag, b32.out_data, exp);
   endtask

   task automatic run8(input string tag, input logic [1:0] mode, input logic [2:0] sh,
                       input logic [7:0] num, input logic [7:0] exp);
      int lat;
      lat = 0;
      @(negedge clk);
      b8.out_ready = 1'b1;
      b8.in_mode   = mode;
      b8.in_shift  = sh;
      b8.in_num    = num;
      b8.in_valid  = 1'b1;
      while (lat < 20) begin
         @(negedge clk);
         b8.in_valid = 1'b0;
         lat++;
         if (b8.out_valid) break;
      end
      check({tag, "_lat"}, lat, 3);
      check(tag, {24'h0, b8.out_data}, {24'h0, exp});
   endtask

   logic [1:0]  s_mode [8] = '{2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b10, 2'b00, 2'b10};
   logic [4:0]  s_sh   [8] = '{5'd4, 5'd4, 5'd4, 5'd8, 5'd16, 5'd2, 5'd16, 5'd1};
   logic [31:0] s_num  [8] = '{32'h1, 32'hF0, 32'hF000_0000, 32'h3, 32'h8000_0000,
                               32'h4000_0000, 32'hABCD, 32'h8000_0001};
   logic [31:0] s_exp  [8] = '{32'h10, 32'h0F, 32'hFF00_0000, 32'h300, 32'h8000,
                               32'h1000_0000, 32'hABCD_0000, 32'hC000_0000};

   initial begin
      int idx, ret, cyc, seen;
      logic [31:0] ror_a, ror_b;
`ifdef SHIFTER_ROTATE_EN
      ror_a = 32'h8000_0000;
      ror_b = 32'h7812_3456;
`else
      ror_a = 32'h0;
      ror_b = 32'h0012_3456;
`endif
      b32.in_valid = 1'b0; b32.in_mode = 2'b00; b32.in_shift = '0; b32.in_num = '0;
      b32.out_ready = 1'b1;
      b8.in_valid = 1'b0; b8.in_mode = 2'b00; b8.in_shift = '0; b8.in_num = '0;
      b8.out_ready = 1'b1;

      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1;
      check("rst_out_valid", {31'h0, b32.out_valid}, 32'h0);
      check("rst_out_data", b32.out_data, 32'h0);
      check("rst_in_ready", {31'h0, b32.in_ready}, 32'h1);
      check("rst_out_valid8", {31'h0, b8.out_valid}, 32'h0);

      run32("sll_127_6", 2'b00, 5'd6, 32'd127, 32'h0000_1FC0);
      run32("srl_127_6", 2'b01, 5'd6, 32'd127, 32'h0000_0001);
      run32("sll_127_31", 2'b00, 5'd31, 32'd127, 32'h8000_0000);
      run32("sra_min_31", 2'b10, 5'd31, 32'h8000_0000, 32'hFFFF_FFFF);
      run32("srl_min_31", 2'b01, 5'd31, 32'h8000_0000, 32'h0000_0001);
      run32("sll_0", 2'b00, 5'd0, 32'd127, 32'd127);
      run32("srl_0", 2'b01, 5'd0, 32'd127, 32'd127);
      run32("sra_0", 2'b10, 5'd0, 32'd127, 32'd127);
      run32("ror_0", 2'b11, 5'd0, 32'd127, 32'd127);
      run32("ror_1_1", 2'b11, 5'd1, 32'h1, ror_a);
      run32("ror_8", 2'b11, 5'd8, 32'h1234_5678, ror_b);

      // Back-to-back stream with a consumer stall on cycles 6..9.
      idx = 0; ret = 0; cyc = 0;
      while (ret < 8 && cyc < 60) begin
         @(negedge clk);
         b32.out_ready = !(cyc >= 6 && cyc <= 9);
         if (idx < 8) begin
            b32.in_mode  = s_mode[idx];
            b32.in_shift = s_sh[idx];
            b32.in_num   = s_num[idx];
            b32.in_valid = 1'b1;
         end else begin
            b32.in_valid = 1'b0;
         end
         #1;
         if (b32.out_valid && !b32.out_ready) begin
            check("stall_hold", b32.out_data, s_exp[ret]);
            check("stall_in_ready", {31'h0, b32.in_ready}, 32'h0);
         end
         if (b32.out_valid && b32.out_ready) begin
            check("stream_data", b32.out_data, s_exp[ret]);
            ret++;
         end
         if (b32.in_valid && b32.in_ready) idx++;
         cyc++;
      end
      check("stream_count", ret, 8);
      b32.in_valid = 1'b0;
      b32.out_ready = 1'b1;
      seen = 0;
      repeat (4) begin
         @(negedge clk);
         if (b32.out_valid) seen++;
      end
      check("stream_no_dup", seen, 0);

      // Reset with three operands in flight, the oldest stalled at the output.
      b32.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         b32.in_mode  = 2'b00;
         b32.in_shift = 5'(i + 1);
         b32.in_num   = 32'h1;
         b32.in_valid = 1'b1;
      end
      @(negedge clk);
      b32.in_valid = 1'b0;
      repeat (2) @(negedge clk);
      check("pre_rst_valid", {31'h0, b32.out_valid}, 32'h1);
      check("pre_rst_data", b32.out_data, 32'h2);
      rst = 1'b1;
      #1;
      check("mid_rst_valid", {31'h0, b32.out_valid}, 32'h0);
      check("mid_rst_data", b32.out_data, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      b32.out_ready = 1'b1;
      #1;
      check("post_rst_in_ready", {31'h0, b32.in_ready}, 32'h1);
      seen = 0;
      repeat (10) begin
         @(negedge clk);
         if (b32.out_valid) seen++;
      end
      check("post_rst_no_stale", seen, 0);
      run32("post_rst_sra", 2'b10, 5'd4, 32'h8000_0000, 32'hF800_0000);

      run8("w8_sra_90_3", 2'b10, 3'd3, 8'h90, 8'hF2);
      run8("w8_sll_0f_4", 2'b00, 3'd4, 8'h0F, 8'hF0);
      run8("w8_srl_90_7", 2'b01, 3'd7, 8'h90, 8'h01);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/barrel_shift_pipe.md
# barrel_shift_pipe

Parametrised, pipelined successor to the team's combinational 32-bit left/right shifter. It takes a WIDTH-bit operand, a shift amount and a 2-bit mode, and produces the shifted result after one register stage per amount bit. It supports logical left, logical right, arithmetic right and (optionally) rotate right. A valid/ready handshake with full backpressure lets it sit between the operand-fetch and writeback stages of the datapath.

## Interface
Parameters:
- WIDTH, 32: operand width; power of two, ≥ 4.
- SHW, $clog2(WIDTH): shift-amount width and stage count; derived, never overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset; asynchronous, active-high.
- in_valid  input  1  operand presented.
- in_ready  output  1  block accepts the operand this cycle.
- in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_shift  input  SHW  shift amount, 0..WIDTH-1.
- in_num  input  WIDTH  operand.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.

## Operation
- Pipeline of SHW stages. Stage k (k = 0..SHW-1) shifts its data by 2^k when the amount bit k is 1; otherwise the data passes unchanged.
- Each stage registers valid, data, mode and the remaining amount bits.
- Fill rules:
  - SLL: zeros enter at the LSB.
  - SRL: zeros enter at the MSB.
  - SRA: the current MSB is replicated. The MSB is invariant across stages, so the sign of in_num is preserved.
  - ROR: bits leaving the LSB re-enter at the MSB.
- Shift by 0 returns in_num unchanged in every mode.
- No modulo or saturation is applied; amounts are limited to WIDTH-1 by port width.
- Global stall: advance = !out_valid || out_ready.
  - When advance is 1, every stage loads from its predecessor.
  - When advance is 0, every stage holds its contents.
- in_ready = advance, a combinational function of out_valid and out_ready.
- An operand is accepted when in_valid && in_ready.
- Bubbles (valid = 0) propagate as ordinary entries; there is no bubble collapsing.
- Results leave in acceptance order.

## Timing
- Latency: exactly SHW cycles from acceptance to out_valid when unstalled (5 for WIDTH = 32).
- Throughput: one operand per cycle while out_ready stays high.
- Stall: while out_valid && !out_ready, out_data and out_valid hold stable and in_ready = 0.
- Simultaneous out_ready and in_valid on a full pipe: the result is retired and the new operand is accepted in the same cycle.
- Reset (asynchronous, at any time, including mid-operation):
  - All stage valid bits clear, so out_valid = 0 and all in-flight operands are discarded.
  - out_data = 0 and all data/mode/amount registers = 0.
  - in_ready = 1 from the first cycle after rst deasserts.
- A mode or amount change on the input never affects operands already in flight; each carries its own copy.

## Configuration
- SHIFTER_ROTATE_EN defined: mode 11 performs rotate right, and wrap-around logic is present in every stage.
- SHIFTER_ROTATE_EN undefined: no rotate logic is synthesised, and mode 11 behaves exactly as SRL (01).
- The macro has no other effect on the interface or on latency.

## Structure
- Package shifter_pkg:
  - enum shift_mode_t: SLL = 2'b00, SRL = 2'b01, SRA = 2'b10, ROR = 2'b11.
  - Localparam for the mode width.
- Sub-module shift_stage (parameters WIDTH and DIST = 2^k):
  - Combinational single-distance shifter/rotator.
  - Instantiated SHW times by a generate loop.
  - The top level owns all pipeline registers and the stall logic.

## Test plan
- SLL, in_num = 127, in_shift = 6, out_ready held 1 → after 5 cycles out_data = 0x00001FC0; SRL with the same inputs → 0x00000001.
- SLL 127 by 31 → 0x80000000; SRA 0x80000000 by 31 → 0xFFFFFFFF; SRL 0x80000000 by 31 → 0x00000001; any mode with shift 0 on 127 → 127.
- ROR 0x00000001 by 1 → 0x80000000 with SHIFTER_ROTATE_EN defined; the same stimulus without the macro → 0x00000000.
- Stream 8 back-to-back operands with out_ready = 0 for cycles 6–9 → out_data holds, in_ready = 0 while stalled, all 8 results arrive in order with none lost or duplicated.
- Assert rst for one cycle with 3 operands in flight → out_valid = 0 and out_data = 0 immediately; no stale results ever appear; a fresh operand after release completes in 5 cycles.
- WIDTH = 8 instance (SHW = 3): SRA 0x90 by 3 → 0xF2, latency 3 cycles.
